// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register for the 5-stage MIPS core.
// Owns the fetch PC, drives the instruction-memory address and latches the
// fetched word into IRD/pcD. An all-zero IRD is an empty slot (bubble).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] IRD,
  output logic [31:0] pcD,
  output logic        jump_redirect
);

  localparam logic [5:0] OP_J = 6'b000010;

  logic [31:0] pc_q, ird_q, pcd_q;
  logic [31:0] pc_n, ird_n, pcd_n;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic        jump_in_id;

  assign pc_plus4    = pc_q + 32'd4;
  assign jump_in_id  = (ird_q[31:26] == OP_J);
  assign jump_target = {pcd_q[31:28], ird_q[25:0], 2'b00};

  // jump redirects only when the ID stage is allowed to advance
  always_comb begin
    jump_redirect = 1'b0;
    if (!reset && stall && jump_in_id)
      jump_redirect = 1'b1;
  end

  // next-state selection; an older branch outranks everything else
  always_comb begin
    pc_n  = pc_q;
    ird_n = ird_q;
    pcd_n = pcd_q;
    if (br_taken) begin
      pc_n  = br_target;
      ird_n = BUBBLE;
      pcd_n = 32'd0;
    end else if (!stall) begin
      pc_n  = pc_q;
      ird_n = ird_q;
      pcd_n = pcd_q;
    end else if (jump_in_id) begin
      pc_n  = jump_target;
      ird_n = BUBBLE;
      pcd_n = 32'd0;
    end else if (!imem_ready) begin
      pc_n  = pc_q;
      ird_n = BUBBLE;
      pcd_n = 32'd0;
    end else begin
      pc_n  = pc_plus4;
      ird_n = imem_rdata;
      pcd_n = pc_plus4;
    end
  end

  // PC and IF/ID register, synchronous reset wins every edge
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      ird_q <= BUBBLE;
      pcd_q <= 32'd0;
    end else begin
      pc_q  <= pc_n;
      ird_q <= ird_n;
      pcd_q <= pcd_n;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign IRD       = ird_q;
  assign pcD       = pcd_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each driven cycle pushes the expected
// post-edge {pc, IRD, pcD}; the entry is popped and compared after the edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, imem_ready;
  logic [31:0] br_target, imem_rdata;
  logic [31:0] imem_addr, pc, IRD, pcD;
  logic        jump_redirect;

  int n_cmp = 0;
  int n_bad = 0;

  logic [95:0] sb_q[$];
  logic [31:0] m_pc, m_ird, m_pcd;

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUBBLE(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .pc(pc), .IRD(IRD), .pcD(pcD),
    .jump_redirect(jump_redirect)
  );

  always #5 clk = ~clk;

  // instruction memory image: word[i] = 0x2000_0000 + i, with two patched words
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h8C01_0000;
    if (a == 32'h0000_0020) return 32'h0800_0040;
    return 32'h2000_0000 + (a >> 2);
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // one clock of stimulus: drive, check combinational outputs, predict, edge, compare
  task automatic step(input logic rst, input logic st, input logic bt,
                      input logic [31:0] bta, input logic rdy);
    logic        jr;
    logic [31:0] e_pc, e_ird, e_pcd;
    logic [95:0] e;
    @(negedge clk);
    reset = rst; stall = st; br_taken = bt; br_target = bta; imem_ready = rdy;
    #1;
    jr = !rst && st && (m_ird[31:26] == 6'b000010);
    chk("jump_redirect", {31'd0, jump_redirect}, {31'd0, jr});
    chk("imem_addr", imem_addr, m_pc);
    if (rst)          begin e_pc = 32'h0;  e_ird = 32'h0; e_pcd = 32'h0; end
    else if (bt)      begin e_pc = bta;    e_ird = 32'h0; e_pcd = 32'h0; end
    else if (!st)     begin e_pc = m_pc;   e_ird = m_ird; e_pcd = m_pcd; end
    else if (jr)      begin e_pc = {m_pcd[31:28], m_ird[25:0], 2'b00};
                            e_ird = 32'h0; e_pcd = 32'h0; end
    else if (!rdy)    begin e_pc = m_pc;   e_ird = 32'h0; e_pcd = 32'h0; end
    else              begin e_pc = m_pc + 32'd4; e_ird = mem_word(m_pc);
                            e_pcd = m_pc + 32'd4; end
    sb_q.push_back({e_pc, e_ird, e_pcd});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("pc",  pc,  e[95:64]);
      chk("IRD", IRD, e[63:32]);
      chk("pcD", pcD, e[31:0]);
      m_pc = e[95:64]; m_ird = e[63:32]; m_pcd = e[31:0];
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b1; br_taken = 1'b0; br_target = 32'h0; imem_ready = 1'b1;
    m_pc = 32'hx; m_ird = 32'hx; m_pcd = 32'hx;

    // reset: model state is unknown until the first reset edge
    @(negedge clk);
    @(posedge clk); #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ird", IRD, 32'h0);
    chk("rst_pcd", pcD, 32'h0);
    m_pc = 32'h0; m_ird = 32'h0; m_pcd = 32'h0;
    step(1, 1, 0, 32'h0, 1);

    // sequential stream up to pc=0x10 with the load in IRD
    repeat (4) step(0, 1, 0, 32'h0, 1);
    chk("str_pc", pc, 32'h0000_0010);
    chk("str_ird", IRD, 32'h8C01_0000);
    chk("str_pcd", pcD, 32'h0000_0010);

    // hold for three edges
    repeat (3) step(0, 0, 0, 32'h0, 1);
    chk("hold_pc", pc, 32'h0000_0010);
    chk("hold_ird", IRD, 32'h8C01_0000);
    chk("hold_pcd", pcD, 32'h0000_0010);
    step(0, 1, 0, 32'h0, 1);
    chk("resume_ird", IRD, 32'h2000_0004);

    // run until the jump sits in ID
    repeat (4) step(0, 1, 0, 32'h0, 1);
    chk("jmp_ird", IRD, 32'h0800_0040);
    chk("jmp_pcd", pcD, 32'h0000_0024);
    chk("jmp_jr", {31'd0, jump_redirect}, 32'd1);
    step(0, 1, 0, 32'h0, 1);
    chk("jmp_pc", pc, 32'h0000_0100);
    chk("jmp_bubble", IRD, 32'h0);
    step(0, 1, 0, 32'h0, 1);
    chk("jmp_tgt_ird", IRD, 32'h2000_0040);

    // wait states at 0x40
    step(0, 1, 1, 32'h0000_0040, 1);
    repeat (2) step(0, 1, 0, 32'h0, 0);
    chk("ws_pc", pc, 32'h0000_0040);
    chk("ws_ird", IRD, 32'h0);
    step(0, 1, 0, 32'h0, 1);
    chk("ws_pc2", pc, 32'h0000_0044);
    chk("ws_ird2", IRD, 32'h2000_0010);

    // branch beats stall, jump in ID and wait state
    step(0, 1, 1, 32'h0000_0020, 1);
    step(0, 1, 0, 32'h0, 1);
    chk("bp_jmp_in_id", IRD, 32'h0800_0040);
    step(0, 0, 1, 32'h0000_0200, 0);
    chk("bp_pc", pc, 32'h0000_0200);
    chk("bp_ird", IRD, 32'h0);
    chk("bp_pcd", pcD, 32'h0);

    // PC wrap
    step(0, 1, 1, 32'hFFFF_FFFC, 1);
    step(0, 1, 0, 32'h0, 1);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_ird", IRD, 32'h5FFF_FFFF);

    // reset coincident with a branch, then first fetch at RESET_PC
    step(0, 1, 0, 32'h0, 1);
    step(1, 0, 1, 32'h0000_0200, 0);
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_ird", IRD, 32'h0);
    step(0, 1, 0, 32'h0, 1);
    chk("mrst_fetch", IRD, 32'h2000_0000);

    // random mix against the scoreboard model
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0), {24'd0, 6'($urandom_range(0, 63)), 2'b00},
           ($urandom_range(0, 4) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the 5-stage MIPS core.
- Owns the PC and drives the instruction-memory address.
- Latches the fetched word into IRD/pcD, the ID-stage instruction consumed by the hazard (stall) unit.
- Honours the stall unit's hold request, MEM-stage branch redirects, ID-stage jump redirects and instruction-memory wait states. All-zero IRD denotes an empty slot (bubble).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
BUBBLE, 32'h0000_0000, word written to IRD when a slot is squashed or empty (must stay all-zero; downstream treats IRD==0 as empty)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
stall  input  1  hazard-unit output, ACTIVE-LOW: 0 = hold IF and ID, 1 = advance
br_taken  input  1  MEM-stage branch (beq/bne) resolved taken
br_target  input  32  MEM-stage branch target address
imem_rdata  input  32  instruction word at imem_addr, combinational, valid when imem_ready=1
imem_ready  input  1  instruction memory has valid data this cycle
imem_addr  output  32  fetch address (= pc)
pc  output  32  current fetch PC
IRD  output  32  instruction held in ID stage
pcD  output  32  PC+4 of the instruction in IRD (0 when IRD is a bubble)
jump_redirect  output  1  combinational: jump in ID is redirecting fetch this cycle

Behaviour:
- Reset (sync, highest priority): pc<=RESET_PC, IRD<=BUBBLE, pcD<=0. jump_redirect=0 while reset=1. br_taken, stall and imem_ready are ignored.
- pc+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- jump_redirect = stall & (IRD[31:26]==6'b000010). Jump target jt = {pcD[31:28], IRD[25:0], 2'b00}.
- Per-edge priority, highest first (reset excepted):
  1. br_taken=1: pc<=br_target; IRD<=BUBBLE; pcD<=0. Overrides stall=0, a jump in ID and imem_ready=0; the branch comes from an older instruction, so both younger slots are squashed.
  2. stall=0: pc, IRD and pcD all hold. Any jump in ID is deferred until stall returns to 1.
  3. jump_redirect=1: pc<=jt; IRD<=BUBBLE; pcD<=0. The word fetched this cycle is discarded regardless of imem_ready.
  4. imem_ready=0: pc holds; IRD<=BUBBLE; pcD<=0. The ID instruction advances and a bubble enters.
  5. Otherwise: IRD<=imem_rdata; pcD<=pc+4; pc<=pc+4.
- Latency: an instruction enters IRD one edge after imem_ready=1 at its address.
  - A taken branch costs the two squashed slots above plus whatever is already in EX (EX/MEM flushing is downstream's job).
  - A jump costs one bubble.
- A fetched all-zero word (sll $0,$0,0) is indistinguishable from a bubble; this is accepted.
- A reset asserted mid-stall or mid-redirect wins the same edge; the first fetch after reset release is at RESET_PC.
- br_target and jt are not alignment-checked; the low 2 bits pass through unchanged.
- No combinational path from imem_rdata to any output except via registers. imem_addr is driven directly from the pc register.

Test Plan:
- Reset, then imem_ready=1, stall=1, memory word[i]=0x2000_0000+i → pc 0,4,8,…; IRD lags pc by one edge; pcD = address+4.
- Hold: stall=0 for 3 cycles with pc=0x10 and IRD=0x8C01_0000 → pc, IRD and pcD unchanged for all 3 edges; normal stream resumes on the edge after stall=1.
- Jump: IRD=0x0800_0040 at pcD=0x0000_0024 with stall=1 → jump_redirect=1; next pc=0x0000_0100; IRD=0 for one cycle; then the instruction at 0x100 appears.
- Branch priority: br_taken=1, br_target=0x0000_0200, stall=0, jump in IRD, imem_ready=0 simultaneously → pc=0x200, IRD=0, pcD=0 next edge.
- Wait states: imem_ready=0 for 2 cycles at pc=0x40 → pc stays 0x40 and IRD=0 for 2 edges; word at 0x40 latches on the third edge; pc becomes 0x44.
- Wrap and mid-operation reset: pc=0xFFFF_FFFC advancing → pc=0 next edge. Reset=1 coincident with br_taken=1 → pc=RESET_PC, IRD=0, pcD=0.
